// File: rtl/apb_pkg.sv
// Shared definitions for the two-slave APB subsystem.
//   AW        : request address width; the top bit selects the slave
//   DW        : data width
//   MEM_DEPTH : locations per slave register file
//   LOC_W     : location index width inside one slave
//   apb_state_e : master FSM states
package apb_pkg;

  localparam int AW        = 9;
  localparam int DW        = 8;
  localparam int MEM_DEPTH = 256;
  localparam int LOC_W     = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave.sv
// Zero-wait-state APB register-file slave (MEM_DEPTH x DW).
// Ports:
//   pclk, presetn : clock, synchronous active-low reset (clears the memory)
//   psel_i        : slave selected (SETUP and ACCESS)
//   penable_i     : ACCESS phase
//   pwrite_i      : 1 = write, 0 = read
//   paddr_i       : location within this slave
//   pwdata_i      : write data
//   prdata_o      : read data, driven during a read ACCESS, 0 otherwise
//   pready_o      : always ready (no wait states)
module apb_slave
  import apb_pkg::*;
#(
  parameter int DW = apb_pkg::DW
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             psel_i,
  input  logic             penable_i,
  input  logic             pwrite_i,
  input  logic [LOC_W-1:0] paddr_i,
  input  logic [DW-1:0]    pwdata_i,
  output logic [DW-1:0]    prdata_o,
  output logic             pready_o
);

  logic [DW-1:0] mem_q [MEM_DEPTH];

  // NOTE: the memory is cleared by reset on purpose: unwritten locations must
  // read back as 0, so this array cannot map onto a plain uninitialised RAM.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (psel_i && penable_i && pwrite_i) begin
      mem_q[paddr_i] <= pwdata_i;
    end
  end

  assign prdata_o = (psel_i && penable_i && !pwrite_i) ? mem_q[paddr_i] : '0;
  assign pready_o = 1'b1;

endmodule

// File: rtl/apb_modport.sv
// Two-slave APB subsystem: request-to-APB master FSM, request latch,
// slave decode on the address MSB, PRDATA mux and registered read return.
// Ports:
//   pclk, presetn      : clock, synchronous active-low reset
//   transfer           : request valid, sampled every rising edge
//   read_write         : 1 = read, 0 = write
//   apb_write_paddr    : write address ([AW-1] = slave select)
//   apb_write_data     : write data
//   apb_read_paddr     : read address (same decode)
//   apb_read_data_out  : last completed read data, held until the next read
module apb_modport
  import apb_pkg::*;
#(
  parameter int AW = apb_pkg::AW,
  parameter int DW = apb_pkg::DW
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          transfer,
  input  logic          read_write,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [DW-1:0] apb_write_data,
  input  logic [AW-1:0] apb_read_paddr,
  output logic [DW-1:0] apb_read_data_out
);

  apb_state_e    state_q, state_d;
  logic          pwrite_q;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q;
  logic [DW-1:0] rdata_q;

  logic          psel, psel1, psel2, penable, pready, load_req;
  logic          pready1, pready2;
  logic [DW-1:0] prdata1, prdata2, prdata;

  // NOTE: every signal assigned here gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          state_d  = SETUP;
          load_req = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d  = transfer ? SETUP : IDLE;
          load_req = transfer;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      // The request is captured only on entry to SETUP, so input changes
      // during SETUP/ACCESS cannot disturb the transfer in flight.
      if (load_req) begin
        pwrite_q <= !read_write;
        paddr_q  <= read_write ? apb_read_paddr : apb_write_paddr;
        pwdata_q <= apb_write_data;
      end
      if (penable && pready && !pwrite_q) rdata_q <= prdata;
    end
  end

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);
  assign psel1   = psel && !paddr_q[AW-1];
  assign psel2   = psel &&  paddr_q[AW-1];
  assign pready  = paddr_q[AW-1] ? pready2 : pready1;
  assign prdata  = paddr_q[AW-1] ? prdata2 : prdata1;

  assign apb_read_data_out = rdata_q;

  apb_slave #(.DW(DW)) u_slave1 (
    .pclk      (pclk),
    .presetn   (presetn),
    .psel_i    (psel1),
    .penable_i (penable),
    .pwrite_i  (pwrite_q),
    .paddr_i   (paddr_q[LOC_W-1:0]),
    .pwdata_i  (pwdata_q),
    .prdata_o  (prdata1),
    .pready_o  (pready1)
  );

  apb_slave #(.DW(DW)) u_slave2 (
    .pclk      (pclk),
    .presetn   (presetn),
    .psel_i    (psel2),
    .penable_i (penable),
    .pwrite_i  (pwrite_q),
    .paddr_i   (paddr_q[LOC_W-1:0]),
    .pwdata_i  (pwdata_q),
    .prdata_o  (prdata2),
    .pready_o  (pready2)
  );

endmodule

// File: tb/tb_apb_modport.sv
// Self-checking bench for apb_modport: directed scenarios plus randomized
// transfers against a flat 512-entry memory model addressed by the full
// 9-bit request address.
module tb_apb_modport;
  import apb_pkg::*;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       transfer;
  logic       read_write;
  logic [8:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [8:0] apb_read_paddr;
  logic [7:0] apb_read_data_out;

  apb_modport dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit         rd;
    logic [8:0] addr;
    logic [7:0] data;
  } req_t;

  logic [7:0] model_mem [512];
  logic [7:0] exp_rdata;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 512; i++) model_mem[i] = 8'h00;
    exp_rdata = 8'h00;
  endfunction

  function automatic void model_apply(input req_t r);
    if (r.rd) exp_rdata = model_mem[r.addr];
    else      model_mem[r.addr] = r.data;
  endfunction

  // Drive a request; the unused address port gets junk so the bench notices
  // if the wrong address is latched.
  task automatic drive_req(input req_t r);
    transfer        = 1'b1;
    read_write      = r.rd;
    apb_read_paddr  = r.rd ? r.addr : 9'($urandom);
    apb_write_paddr = r.rd ? 9'($urandom) : r.addr;
    apb_write_data  = r.rd ? 8'($urandom) : r.data;
  endtask

  task automatic scramble_inputs();
    read_write      = 1'($urandom);
    apb_read_paddr  = 9'($urandom);
    apb_write_paddr = 9'($urandom);
    apb_write_data  = 8'($urandom);
  endtask

  task automatic check_phase(input string tag, input apb_state_e st, input logic [8:0] addr);
    check({tag, " state"},   32'(dut.state_q), 32'(st));
    check({tag, " psel1"},   32'(dut.psel1),   32'(!addr[8]));
    check({tag, " psel2"},   32'(dut.psel2),   32'(addr[8]));
    check({tag, " penable"}, 32'(dut.penable), 32'(st == ACCESS));
  endtask

  // Single isolated transfer: request edge, SETUP, ACCESS, back to IDLE.
  task automatic do_xfer(input bit rd, input logic [8:0] addr, input logic [7:0] data,
                         input string tag);
    req_t r;
    r.rd = rd; r.addr = addr; r.data = data;
    @(negedge pclk);
    drive_req(r);
    @(posedge pclk); #1;
    transfer = 1'b0;
    scramble_inputs();
    check_phase({tag, " setup"}, SETUP, addr);
    @(posedge pclk); #1;
    check_phase({tag, " access"}, ACCESS, addr);
    model_apply(r);
    @(posedge pclk); #1;
    check({tag, " rdata"}, 32'(apb_read_data_out), 32'(exp_rdata));
    check({tag, " idle"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge pclk);
    presetn  = 1'b0;
    transfer = 1'b0;
    repeat (cycles) @(posedge pclk);
    #1;
    model_reset();
    check("rst rdata",   32'(apb_read_data_out), 32'(exp_rdata));
    check("rst state",   32'(dut.state_q), 32'(IDLE));
    check("rst psel1",   32'(dut.psel1), 32'd0);
    check("rst psel2",   32'(dut.psel2), 32'd0);
    check("rst penable", 32'(dut.penable), 32'd0);
    presetn = 1'b1;
  endtask

  req_t b2b [4];

  initial begin
    presetn = 1'b0; transfer = 1'b0; read_write = 1'b0;
    apb_write_paddr = '0; apb_write_data = '0; apb_read_paddr = '0;
    model_reset();

    // Reset, then read an unwritten location.
    apply_reset(2);
    do_xfer(1'b1, 9'h010, 8'h00, "rd010");

    // Slave 1 write/read.
    do_xfer(1'b0, 9'h005, 8'hA5, "wr005");
    do_xfer(1'b1, 9'h005, 8'h00, "rd005");
    check("s1 data", 32'(apb_read_data_out), 32'h0000_00A5);

    // Slave isolation: same location index, different slaves.
    do_xfer(1'b0, 9'h105, 8'h3C, "wr105");
    do_xfer(1'b0, 9'h005, 8'h5A, "wr005b");
    do_xfer(1'b1, 9'h105, 8'h00, "rd105");
    check("iso 105", 32'(apb_read_data_out), 32'h0000_003C);
    do_xfer(1'b1, 9'h005, 8'h00, "rd005b");
    check("iso 005", 32'(apb_read_data_out), 32'h0000_005A);

    // Back-to-back with transfer held high: SETUP/ACCESS alternate, no IDLE.
    b2b[0] = '{1'b0, 9'h0FF, 8'h11};
    b2b[1] = '{1'b0, 9'h1FF, 8'h22};
    b2b[2] = '{1'b1, 9'h0FF, 8'h00};
    b2b[3] = '{1'b1, 9'h1FF, 8'h00};
    @(negedge pclk);
    for (int i = 0; i < 4; i++) begin
      drive_req(b2b[i]);
      @(posedge pclk); #1;
      check_phase("b2b setup", SETUP, b2b[i].addr);
      check("b2b rdata", 32'(apb_read_data_out), 32'(exp_rdata));
      @(posedge pclk); #1;
      check_phase("b2b access", ACCESS, b2b[i].addr);
      model_apply(b2b[i]);
      if (i == 3) transfer = 1'b0;
    end
    @(posedge pclk); #1;
    check("b2b last rdata", 32'(apb_read_data_out), 32'h0000_0022);
    check("b2b idle", 32'(dut.state_q), 32'(IDLE));

    // Reset during SETUP aborts the write (and reset clears memory anyway).
    @(negedge pclk);
    drive_req('{1'b0, 9'h020, 8'h77});
    @(posedge pclk); #1;
    transfer = 1'b0;
    check("mid setup", 32'(dut.state_q), 32'(SETUP));
    apply_reset(1);
    do_xfer(1'b1, 9'h020, 8'h00, "rd020");
    check("mid data", 32'(apb_read_data_out), 32'h0000_0000);

    // Read data holds across a later write.
    do_xfer(1'b0, 9'h033, 8'h44, "wr033");
    do_xfer(1'b1, 9'h033, 8'h00, "rd033");
    do_xfer(1'b0, 9'h134, 8'h99, "wr134");
    check("hold", 32'(apb_read_data_out), 32'h0000_0044);

    // Randomized transfers over a small address pool to force reuse.
    for (int n = 0; n < 60; n++) begin
      logic [8:0] a;
      a = {1'($urandom), 4'h0, 4'($urandom_range(0, 15))};
      do_xfer(1'($urandom), a, 8'($urandom), "rand");
      repeat ($urandom_range(0, 2)) @(posedge pclk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_modport.md
# apb_modport

Two-slave APB subsystem. An APB master converts a simple transfer request (`transfer`, `read_write`, separate read and write addresses, write data) into APB SETUP/ACCESS cycles. Address bit 8 decodes the request to one of two 256x8 register-file slaves. The block sits below a testbench-facing or CPU-side request port, and returns read data on `apb_read_data_out`.

## Interface
- `AW`, default 9: request address width; bit AW-1 is the slave select.
- `DW`, default 8: data width.
- `pclk` input 1: single clock, all logic on its rising edge.
- `presetn` input 1: reset, synchronous, active-low.
- `transfer` input 1: request valid. Sampled every rising edge.
- `read_write` input 1: 1 = read, 0 = write.
- `apb_write_paddr` input AW: write address. [8] = slave select, [7:0] = location.
- `apb_write_data` input DW: write data.
- `apb_read_paddr` input AW: read address, same decode as the write address.
- `apb_read_data_out` output DW: registered read data; holds its value until the next read completes.

## Operation
- Master FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSELx=1, PENABLE=0.
  - ACCESS: PSELx=1, PENABLE=1.
- FSM transitions:
  - IDLE goes to SETUP when `transfer`=1, otherwise stays in IDLE.
  - SETUP always goes to ACCESS.
  - ACCESS with PREADY=1 goes to SETUP if `transfer`=1 (back-to-back), otherwise to IDLE.
  - ACCESS with PREADY=0 stays in ACCESS, with all APB signals stable.
- Request capture: when entering SETUP, latch PWRITE = !`read_write`. Latch PADDR = `apb_read_paddr` for a read, `apb_write_paddr` for a write. Latch PWDATA = `apb_write_data`. Inputs that change during ACCESS have no effect on the current transfer.
- Decode: PADDR[8]=0 drives PSEL1; PADDR[8]=1 drives PSEL2. Exactly one PSEL is high in SETUP and ACCESS.
- Slave behaviour (each slave):
  - 256x8 memory, PREADY=1 during ACCESS (zero wait states).
  - Write: at the ACCESS edge, mem[PADDR[7:0]] <= PWDATA.
  - Read: PRDATA = mem[PADDR[7:0]] during ACCESS.
  - The two slaves are independent. Address 0x005 and address 0x105 are different locations.
- Read return: at the ACCESS edge of a read with PREADY=1, `apb_read_data_out` <= PRDATA of the selected slave. Writes leave it unchanged.
- `apb_read_data_out` and the memories are never X after reset. Reading a location that was never written returns 0.

## Timing
- Reset (`presetn`=0 at a rising edge) sets:
  - state to IDLE;
  - PSEL1 = PSEL2 = PENABLE = PWRITE = 0;
  - PADDR = 0 and PWDATA = 0;
  - `apb_read_data_out` = 0;
  - all memory locations in both slaves = 0.
- Reset asserted mid-transfer aborts the transfer: no write is committed and no read data is updated.
- Write latency: `transfer` sampled at edge N, SETUP during cycle N+1, ACCESS during cycle N+2. The memory is written at edge N+2 (end of ACCESS).
- Read latency: same sequence as a write. `apb_read_data_out` is valid after edge N+2, so it is visible 2 cycles after the request edge.
- Back-to-back throughput: one transfer every 2 cycles while `transfer` stays high.
- A write then an immediate read of the same address returns the new data.
- The requester must hold `read_write` and the addresses valid (not X) whenever `transfer`=1.

## Structure
- Shared package `apb_pkg`:
  - constants `AW`=9, `DW`=8, `MEM_DEPTH`=256;
  - FSM state enum {IDLE, SETUP, ACCESS}.
- Sub-module `apb_slave`: PSEL, PENABLE, PWRITE, PADDR[7:0], PWDATA in; PRDATA, PREADY out. Instantiated twice.
- The top contains the master FSM, the request latch, the address decode and the PRDATA mux.

## Test plan
- Reset: hold `presetn`=0 for 2 cycles. Require `apb_read_data_out`=0, state IDLE, PSEL1=PSEL2=PENABLE=0. Then read 0x010; require 0x00.
- Slave 1 write/read: write 0xA5 to 0x005, then read 0x005. Require 0xA5 two cycles after the read request. Require PSEL1 high and PSEL2 low throughout.
- Slave isolation: write 0x3C to 0x105 and 0x5A to 0x005. Read 0x105 and require 0x3C. Read 0x005 and require 0x5A.
- Back-to-back: hold `transfer`=1 and issue writes to 0x0FF=0x11 and 0x1FF=0x22, then reads of both. Require SETUP/ACCESS alternation with no IDLE, and reads returning 0x11 and 0x22.
- Reset mid-operation: start a write of 0x77 to 0x020 and assert reset during SETUP. A later read of 0x020 must return 0x00.
- Hold behaviour: after reading 0x44, issue a write to a different address. Require `apb_read_data_out` to stay 0x44.
